// File: rtl/score4_move_ctrl.sv
// Score 4 move sequencer: button edges -> cursor moves and token drops, then win/full bookkeeping.
// Cursor moves land 1 cycle after the edge; a drop takes WRITE, CHECK, then waits on the checker (bounded).
module score4_move_ctrl #(
  parameter int COLS        = 7,
  parameter int ROWS        = 6,
  parameter int CHK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       put,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic       wr_en,
  output logic [2:0] wr_col,
  output logic [2:0] wr_row,
  output logic       wr_player,
  output logic       chk_start,
  output logic [2:0] chk_col,
  output logic [2:0] chk_row,
  output logic [2:0] cursor_col,
  output logic       player,
  output logic       invalid_move,
  output logic       win_a,
  output logic       win_b,
  output logic       full_panel
);

  localparam int HW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS * ROWS + 1);
  localparam int TW = $clog2(CHK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_CHECK, S_WAIT, S_OVER} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   height [COLS];
  logic [CW-1:0]   count;
  logic [TW-1:0]   tmo;
  logic            left_q, right_q, put_q;
  logic            put_cmd, right_cmd, left_cmd;
  logic            col_full, board_full, tmo_hit, chk_end;

  // Lower-priority edges are masked when a higher one fires in the same cycle.
  assign put_cmd   = put & ~put_q;
  assign right_cmd = right & ~right_q & ~put_cmd;
  assign left_cmd  = left & ~left_q & ~put_cmd & ~right_cmd;

  assign col_full   = (height[cursor_col] == HW'(ROWS));
  assign board_full = (count == CW'(COLS * ROWS));
  assign tmo_hit    = (tmo == TW'(CHK_TIMEOUT - 1));
  assign chk_end    = chk_done | tmo_hit;

  assign wr_col    = cursor_col;
  assign wr_row    = 3'(height[cursor_col]);
  assign wr_player = player;

  // Loaded in reset as well, so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    left_q  <= left;
    right_q <= right;
    put_q   <= put;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    chk_start = 1'b0;
    case (state)
      S_IDLE:  if (put_cmd && !col_full) state_nxt = S_WRITE;
      S_WRITE: begin
        wr_en     = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        chk_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (chk_end) begin
          if ((chk_done && chk_win) || board_full) state_nxt = S_OVER;
          else                                     state_nxt = S_IDLE;
        end
      end
      S_OVER:  state_nxt = S_OVER;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cursor_col   <= '0;
      player       <= 1'b0;
      invalid_move <= 1'b0;
      win_a        <= 1'b0;
      win_b        <= 1'b0;
      full_panel   <= 1'b0;
      count        <= '0;
      tmo          <= '0;
      chk_col      <= '0;
      chk_row      <= '0;
      for (int i = 0; i < COLS; i++) height[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (put_cmd) begin
            invalid_move <= col_full;
          end else if (right_cmd) begin
            if (cursor_col == 3'(COLS - 1)) invalid_move <= 1'b1;
            else begin
              cursor_col   <= cursor_col + 3'd1;
              invalid_move <= 1'b0;
            end
          end else if (left_cmd) begin
            if (cursor_col == 3'd0) invalid_move <= 1'b1;
            else begin
              cursor_col   <= cursor_col - 3'd1;
              invalid_move <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          height[cursor_col] <= height[cursor_col] + 1'b1;
          count              <= count + 1'b1;
          chk_col            <= cursor_col;
          chk_row            <= 3'(height[cursor_col]);
        end
        S_CHECK: tmo <= '0;
        S_WAIT: begin
          tmo <= tmo + 1'b1;
          // A timeout is treated exactly like a non-winning reply.
          if (chk_end) begin
            if (chk_done && chk_win) begin
              if (player) win_b <= 1'b1;
              else        win_a <= 1'b1;
            end else if (board_full) begin
              full_panel <= 1'b1;
            end else begin
              player <= ~player;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score4_move_ctrl.sv
// Directed bench for score4_move_ctrl: a move-level game model predicts writes and status flags.
module tb_score4_move_ctrl;
  localparam int COLS = 7, ROWS = 6, CHK_TIMEOUT = 64;
  localparam int B_LEFT = 0, B_RIGHT = 1, B_PUT = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic left = 1'b0, right = 1'b0, put = 1'b0, chk_done = 1'b0, chk_win = 1'b0;
  logic wr_en, wr_player, chk_start, player, invalid_move, win_a, win_b, full_panel;
  logic [2:0] wr_col, wr_row, chk_col, chk_row, cursor_col;

  score4_move_ctrl #(.COLS(COLS), .ROWS(ROWS), .CHK_TIMEOUT(CHK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
    .chk_done(chk_done), .chk_win(chk_win),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_player(wr_player),
    .chk_start(chk_start), .chk_col(chk_col), .chk_row(chk_row),
    .cursor_col(cursor_col), .player(player), .invalid_move(invalid_move),
    .win_a(win_a), .win_b(win_b), .full_panel(full_panel)
  );

  always #10 clk = ~clk;

  typedef struct {int col; int row; int ply;} wr_t;

  int n_pass = 0, n_total = 0;
  int m_cursor, m_player, m_inv, m_wa, m_wb, m_full, m_over, m_cnt;
  int m_h [COLS];
  wr_t exp_q [$];
  int exp_chk = 0, seen_chk = 0, n_wr = 0;
  int last_col = 0, last_row = 0, obs_col = -1, obs_row = -1, obs_ply = -1;
  bit settled = 1'b0;
  int resp_lat = 3;
  bit resp_win = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_cursor = 0; m_player = 0; m_inv = 0; m_wa = 0; m_wb = 0;
    m_full = 0; m_over = 0; m_cnt = 0;
    for (int i = 0; i < COLS; i++) m_h[i] = 0;
  endtask

  // One accepted command's full effect on the game, applied up front.
  task automatic model_apply(input int btn);
    wr_t e;
    if (m_over) return;
    if (btn == B_LEFT) begin
      if (m_cursor == 0) m_inv = 1;
      else begin m_cursor--; m_inv = 0; end
    end else if (btn == B_RIGHT) begin
      if (m_cursor == COLS - 1) m_inv = 1;
      else begin m_cursor++; m_inv = 0; end
    end else begin
      if (m_h[m_cursor] == ROWS) m_inv = 1;
      else begin
        m_inv = 0;
        e.col = m_cursor; e.row = m_h[m_cursor]; e.ply = m_player;
        exp_q.push_back(e);
        exp_chk++;
        m_h[m_cursor]++;
        m_cnt++;
        if (resp_lat >= 0 && resp_win) begin
          if (m_player == 1) m_wb = 1; else m_wa = 1;
          m_over = 1;
        end else if (m_cnt == COLS * ROWS) begin
          m_full = 1; m_over = 1;
        end else m_player = 1 - m_player;
      end
    end
  endtask

  task automatic drive(input int btn, input int hold, input int settle);
    settled = 1'b0;
    if (btn == B_LEFT) left = 1'b1;
    else if (btn == B_RIGHT) right = 1'b1;
    else put = 1'b1;
    repeat (hold) tick();
    left = 1'b0; right = 1'b0; put = 1'b0;
    repeat (settle) tick();
    check("wr_pending", exp_q.size(), 0);
    check("chk_start_count", seen_chk, exp_chk);
    settled = 1'b1;
  endtask

  task automatic cmd(input int btn, input int hold, input int settle);
    model_apply(btn);
    drive(btn, hold, settle);
  endtask

  task automatic do_reset();
    settled = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    m_reset();
    tick();
    settled = 1'b1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      n_wr++;
      obs_col = wr_col; obs_row = wr_row; obs_ply = wr_player;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_col", wr_col, e.col);
        check("wr_row", wr_row, e.row);
        check("wr_player", wr_player, e.ply);
        last_col = e.col; last_row = e.row;
      end
    end
    if (chk_start) begin
      seen_chk++;
      check("chk_col", chk_col, last_col);
      check("chk_row", chk_row, last_row);
    end
    if (settled) begin
      check("cursor_col", cursor_col, m_cursor);
      check("player", player, m_player);
      check("invalid_move", invalid_move, m_inv);
      check("win_a", win_a, m_wa);
      check("win_b", win_b, m_wb);
      check("full_panel", full_panel, m_full);
    end
  end

  // Checker stand-in: replies resp_lat cycles after chk_start; negative latency means silent.
  always begin
    @(negedge clk);
    if (chk_start && resp_lat >= 0) begin
      repeat (resp_lat) @(posedge clk);
      #1;
      chk_done = 1'b1; chk_win = resp_win;
      @(posedge clk);
      #1;
      chk_done = 1'b0; chk_win = 1'b0;
    end
  end

  initial begin
    m_reset();
    tick(); tick(); tick();
    rst = 1'b1;
    settled = 1'b1;
    repeat (10) tick();
    check("rst_cursor", cursor_col, 0);
    check("rst_player", player, 0);
    check("rst_flags", {invalid_move, win_a, win_b, full_panel}, 0);
    check("rst_no_wr", n_wr, 0);

    // Held put yields one write; checker replies after 3 cycles.
    resp_lat = 3; resp_win = 1'b0;
    cmd(B_PUT, 10, 4);
    check("put1_wr_count", n_wr, 1);
    check("put1_wr_cell", obs_col * 8 + obs_row, 0);
    check("put1_wr_ply", obs_ply, 0);
    check("put1_player", player, 1);
    cmd(B_PUT, 10, 4);
    check("put2_wr_row", obs_row, 1);
    check("put2_wr_ply", obs_ply, 1);
    check("put2_player", player, 0);

    cmd(B_LEFT, 3, 2);
    check("left_at_0_inv", invalid_move, 1);
    check("left_at_0_cursor", cursor_col, 0);
    for (int i = 0; i < 6; i++) cmd(B_RIGHT, 3, 2);
    check("right6_cursor", cursor_col, 6);
    check("right6_inv", invalid_move, 0);
    cmd(B_RIGHT, 3, 2);
    check("right7_inv", invalid_move, 1);
    check("right7_cursor", cursor_col, 6);

    for (int i = 0; i < 6; i++) cmd(B_LEFT, 2, 2);
    for (int i = 0; i < 4; i++) cmd(B_PUT, 10, 4);
    check("col0_top_row", obs_row, 5);
    check("col0_top_ply", obs_ply, 1);
    cmd(B_PUT, 10, 4);
    check("col0_full_inv", invalid_move, 1);
    check("col0_full_no_wr", n_wr, 6);
    check("col0_full_player", player, 0);

    cmd(B_RIGHT, 2, 2);
    cmd(B_PUT, 10, 4);
    check("pre_win_player", player, 1);
    resp_win = 1'b1;
    cmd(B_PUT, 10, 4);
    check("win_b", win_b, 1);
    check("win_a_clear", win_a, 0);
    resp_win = 1'b0;
    cmd(B_PUT, 4, 6);
    cmd(B_LEFT, 2, 2);
    cmd(B_RIGHT, 2, 2);
    check("over_cursor", cursor_col, 1);
    check("over_no_wr", n_wr, 8);

    // Fill the whole panel with a checker that never reports a win.
    do_reset();
    resp_lat = 1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) cmd(B_PUT, 1, 6);
      if (c < COLS - 1) cmd(B_RIGHT, 1, 2);
    end
    check("full_panel_set", full_panel, 1);
    check("full_no_win", {win_a, win_b}, 0);
    check("full_wr_count", n_wr, 8 + 42);

    // Silent checker: the move completes only through the timeout.
    do_reset();
    resp_lat = -1;
    settled = 1'b0;
    model_apply(B_PUT);
    put = 1'b1;
    tick(); tick();
    put = 1'b0;
    repeat (50) tick();
    check("tmo_early_player", player, 0);
    repeat (30) tick();
    check("tmo_wr_pending", exp_q.size(), 0);
    settled = 1'b1;
    check("tmo_player", player, 1);

    // Reset mid-wait with put held through it.
    do_reset();
    settled = 1'b0;
    model_apply(B_PUT);
    put = 1'b1;
    tick();
    put = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    put = 1'b1;
    tick(); tick();
    rst = 1'b1;
    m_reset();
    repeat (5) tick();
    settled = 1'b1;
    repeat (3) tick();
    put = 1'b0;
    tick();
    check("abort_wr_count", n_wr, 8 + 42 + 2);
    check("abort_player", player, 0);
    check("abort_chk_count", seen_chk, exp_chk);
    resp_lat = 3;
    cmd(B_PUT, 4, 8);
    check("abort_height_cleared", obs_row, 0);
    check("abort_after_player", player, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/score4_move_ctrl.md
Name: score4_move_ctrl

Overview:
Game-sequencing controller for the Score 4 panel. It turns the raw left/right/put button levels into single commands and tracks the cursor column and the per-column fill heights. On each put it issues a write to the panel store, then runs the external win-check engine and, when that finishes, updates the player, win and full-panel status. It sits between the button inputs and the panel/VGA datapath inside score4.

Parameters:
COLS, 7, number of panel columns (cursor range 0..COLS-1)
ROWS, 6, number of panel rows (row 0 = bottom)
CHK_TIMEOUT, 64, maximum cycles spent waiting for chk_done before the move is treated as not winning

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset; synchronous, active-low
left  in  1  button level: move cursor left
right  in  1  button level: move cursor right
put  in  1  button level: drop a token in the cursor column
chk_done  in  1  win-check engine finished; one-cycle pulse
chk_win  in  1  win result; valid only while chk_done=1
wr_en  out  1  panel write strobe; one-cycle pulse
wr_col  out  3  column written; valid with wr_en
wr_row  out  3  row written; valid with wr_en
wr_player  out  1  token owner: 0 = player A, 1 = player B
chk_start  out  1  starts the win check; one-cycle pulse
chk_col  out  3  column of the last token; held from chk_start to chk_done
chk_row  out  3  row of the last token; held from chk_start to chk_done
cursor_col  out  3  current cursor column
player  out  1  player to move (0 = A)
invalid_move  out  1  last command was rejected
win_a  out  1  player A has won
win_b  out  1  player B has won
full_panel  out  1  all COLS*ROWS cells are filled with no winner

Behaviour:
- Reset (rst=0 at posedge clk):
  - State goes to IDLE.
  - Cleared to 0: all heights, the token count, cursor_col, player, invalid_move, win_a, win_b, full_panel, wr_en, chk_start.
  - Edge-detect registers load the current button levels, so a button held through reset produces no command.
- Command detection:
  - Each button is registered once; a command is a rising edge (level=1, previous=0).
  - Levels held for many cycles yield exactly one command.
  - When edges coincide, priority is put > right > left; the lower-priority edges are discarded.
  - Edges arriving outside IDLE are discarded.
- IDLE:
  - left: if cursor_col=0, set invalid_move=1 and leave the cursor unchanged. Otherwise decrement the cursor and clear invalid_move. Latency is 1 cycle after the edge. No wrap-around.
  - right: if cursor_col=COLS-1, set invalid_move=1 and leave the cursor unchanged. Otherwise increment the cursor and clear invalid_move. No wrap-around.
  - put: if height[cursor_col]=ROWS, set invalid_move=1 and stay in IDLE (player unchanged). Otherwise clear invalid_move and go to WRITE.
  - invalid_move is sticky until the next accepted command or reset.
- WRITE (1 cycle):
  - Pulse wr_en with wr_col=cursor_col, wr_row=height[col], wr_player=player.
  - Increment height[col] and the token count.
  - Go to CHECK.
- CHECK (1 cycle):
  - Pulse chk_start with chk_col/chk_row equal to the written cell.
  - Clear the timeout counter; go to WAIT_CHK.
- WAIT_CHK:
  - On chk_done:
    - chk_win=1: set win_a (player=0) or win_b (player=1) and go to OVER.
    - chk_win=0 and count=COLS*ROWS: set full_panel and go to OVER.
    - Otherwise toggle player and go to IDLE.
  - If CHK_TIMEOUT cycles pass without chk_done, take the chk_win=0 path.
  - A chk_done outside WAIT_CHK is ignored.
- OVER:
  - All commands are ignored; outputs are frozen until reset.
  - win_a and win_b are never both 1.
  - A win on the final token sets the win flag only; full_panel stays 0.
- Cursor movement never changes the player.
- Put-to-IDLE latency is 3 cycles plus the checker latency.
- Reset in any state, including mid-WAIT_CHK, aborts the move. No wr_en or chk_start pulse follows the reset.

Test Plan:
- Reset then idle 10 cycles -> cursor_col=0, player=0, all flags 0, no wr_en/chk_start pulses.
- put held 10 cycles, checker replies chk_done/chk_win=0 after 3 cycles -> exactly one wr_en (col 0, row 0, player 0), one chk_start, then player=1. A second put gives row 1, player 0.
- left at col 0 -> invalid_move=1, cursor 0. Then right x7 -> cursor 6 after 6 moves; the 7th sets invalid_move=1 and the cursor stays 6.
- 7 puts in column 0 -> the first 6 write rows 0..5 with alternating players; the 7th gives invalid_move=1, no wr_en, player unchanged.
- chk_win=1 on a player-B move -> win_b=1, win_a=0. Subsequent put/left/right produce no wr_en and no cursor change.
- Fill all 42 cells with the checker always returning 0 -> full_panel=1 after the 42nd chk_done. Silent checker -> move completes after CHK_TIMEOUT cycles. Reset asserted in WAIT_CHK -> IDLE with all state cleared.
